// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready on both sides and a pass-through tag.
// Define ALU_FLAGS_EN to add the registered {ovf,carry,neg,zero} flags output.
module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl_sigs,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpSlt  = 4'd3;
    localparam logic [3:0] OpSll  = 4'd4;
    localparam logic [3:0] OpSrl  = 4'd5;
    localparam logic [3:0] OpOr   = 4'd6;
    localparam logic [3:0] OpAnd  = 4'd7;
    localparam logic [3:0] OpXor  = 4'd8;
    localparam logic [3:0] OpFlip = 4'd9;
    localparam logic [3:0] OpSra  = 4'd10;

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q;
    logic [TAG_W-1:0] out_tag_q;

    logic s1_advance, accept;

    assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready   = !s1_valid_q || s1_advance;
    assign accept     = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // A retire and a reload on the same edge keep out_valid high with no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        if (s1_advance) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_ext, sub_ext;
    logic             slt_lt;
    logic [WIDTH-1:0] alu_res;

    assign shamt   = s1_b_q[SHW-1:0];
    assign add_ext = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    // Carry out of A + ~B + 1 is the unsigned no-borrow indication.
    assign sub_ext = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + (WIDTH + 1)'(1);
    assign slt_lt  = $signed(s1_a_q) < $signed(s1_b_q);

    always_comb begin
        alu_res = '0;
        case (s1_op_q)
            OpAdd:   alu_res = add_ext[WIDTH-1:0];
            OpSub:   alu_res = sub_ext[WIDTH-1:0];
            OpSlt:   alu_res = {{(WIDTH - 1){1'b0}}, slt_lt};
            OpSll:   alu_res = s1_a_q << shamt;
            OpSrl:   alu_res = s1_a_q >> shamt;
            OpOr:    alu_res = s1_a_q | s1_b_q;
            OpAnd:   alu_res = s1_a_q & s1_b_q;
            OpXor:   alu_res = s1_a_q ^ s1_b_q;
            OpFlip:  alu_res = {~s1_a_q[WIDTH-1], s1_a_q[WIDTH-2:0]};
            OpSra:   alu_res = $unsigned($signed(s1_a_q) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                s1_op_q  <= ctrl_sigs;
                s1_a_q   <= srcA;
                s1_b_q   <= srcB;
                s1_tag_q <= in_tag;
            end
            if (s1_advance) begin
                result_q  <= alu_res;
                out_tag_q <= s1_tag_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;

`ifdef ALU_FLAGS_EN
    logic       carry_c, ovf_c;
    logic [3:0] flags_q;

    always_comb begin
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        if (s1_op_q == OpAdd) begin
            carry_c = add_ext[WIDTH];
            ovf_c   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != s1_a_q[WIDTH-1]);
        end else if (s1_op_q == OpSub) begin
            carry_c = sub_ext[WIDTH];
            ovf_c   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != s1_a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if (s1_advance) begin
            flags_q <= {ovf_c, carry_c, alu_res[WIDTH-1], alu_res == '0};
        end
    end

    assign flags = flags_q;
`else
    logic unused_carry;
    assign unused_carry = add_ext[WIDTH] ^ sub_ext[WIDTH];
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized traffic against an
// in-order arithmetic reference model. Flags are checked only when ALU_FLAGS_EN is defined.
module tb_alu_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ctrl_sigs;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] out_tag;
`ifdef ALU_FLAGS_EN
    logic [3:0]       flags_w;
`endif

    alu_pipe #(
        .WIDTH(WIDTH),
        .TAG_W(TAG_W)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ctrl_sigs(ctrl_sigs),
        .srcA     (srcA),
        .srcB     (srcB),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .out_tag  (out_tag)
`ifdef ALU_FLAGS_EN
        ,
        .flags    (flags_w)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        int          acc;
    } op_t;

    op_t q[$];
    int  cyc      = 0;
    int  checks   = 0;
    int  errors   = 0;
    int  retired  = 0;
    int  accepted = 0;

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    // Returns {ovf, carry, neg, zero, result} from plain integer arithmetic.
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned ua, ub, usum;
        longint          sa, sb, ls;
        int              ia, ib, sh;
        logic [31:0]     r;
        logic            c, v;
        ua = a;
        ub = b;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        sh = int'(b % 32);
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            4'd1: begin
                usum = ua + ub;
                r    = usum[31:0];
                c    = usum[32];
                ls   = sa + sb;
                v    = ls != longint'(int'(ls));
            end
            4'd2: begin
                r  = a - b;
                c  = ua >= ub;
                ls = sa - sb;
                v  = ls != longint'(int'(ls));
            end
            4'd3:    r = (sa < sb) ? 32'd1 : 32'd0;
            4'd4:    r = a << sh;
            4'd5:    r = a >> sh;
            4'd6:    r = a | b;
            4'd7:    r = a & b;
            4'd8:    r = a ^ b;
            4'd9:    r = a ^ 32'h8000_0000;
            4'd10:   r = 32'(ia >>> sh);
            default: r = '0;
        endcase
        return {v, c, r[31], r == 32'd0, r};
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input logic ordy);
        in_valid  = v;
        ctrl_sigs = op;
        srcA      = a;
        srcB      = b;
        in_tag    = tag;
        out_ready = ordy;
    endtask

    // Called just after a rising edge with inputs already driven; samples on the falling edge.
    task automatic cycle_step();
        logic [35:0] e;
        logic        exp_ov;
        op_t         n;
        @(negedge clock);
        cyc++;
        exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
        check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
        check_eq("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
        if (out_valid && q.size() > 0) begin
            e = model(q[0].op, q[0].a, q[0].b);
            check_eq("result", result, e[31:0]);
            check_eq("out_tag", 32'(out_tag), 32'(q[0].tag));
`ifdef ALU_FLAGS_EN
            check_eq("flags", 32'(flags_w), 32'(e[35:32]));
`endif
            if (out_ready) begin
                void'(q.pop_front());
                retired++;
            end
        end
        if (in_valid && in_ready) begin
            n.op  = ctrl_sigs;
            n.a   = srcA;
            n.b   = srcB;
            n.tag = in_tag;
            n.acc = cyc;
            q.push_back(n);
            accepted++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
            cycle_step();
        end
        check_eq("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Single isolated op into an empty pipe; expected values are literal constants.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] er, input logic [3:0] ef,
                          input string nm);
        drive(1'b1, op, a, b, tag, 1'b1);
        check_eq({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
        check_eq({nm, "_early_valid"}, 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        check_eq({nm, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({nm, "_result"}, result, er);
        check_eq({nm, "_tag"}, 32'(out_tag), 32'(tag));
`ifdef ALU_FLAGS_EN
        check_eq({nm, "_flags"}, 32'(flags_w), 32'(ef));
`else
        if (ef !== ef) $display("unreachable");
`endif
        @(posedge clock);
        #1;
        check_eq({nm, "_retired"}, 32'(out_valid), 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] specials [6];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h0000_0001;
        specials[5] = 32'h0000_001F;
        if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_n = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_out_tag", 32'(out_tag), 32'd0);
`ifdef ALU_FLAGS_EN
        check_eq("rst_flags", 32'(flags_w), 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op(4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 32'h8000_0000, 4'b1010, "add_ovf");
        run_op(4'd2, 32'd5, 32'd7, 4'd5, 32'hFFFF_FFFE, 4'b0010, "sub_neg");
        run_op(4'd3, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'd1, 4'b0000, "slt");
        run_op(4'd10, 32'h8000_0000, 32'd4, 4'd7, 32'hF800_0000, 4'b0010, "sra");
        run_op(4'd4, 32'h1234_5678, 32'h21, 4'd8, 32'h2468_ACF0, 4'b0000, "sll_mask");
        run_op(4'd9, 32'h0000_0005, 32'd0, 4'd10, 32'h8000_0005, 4'b0010, "sign_flip");
        run_op(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 32'd0, 4'b0001, "op_f");
        run_op(4'd2, 32'd9, 32'd9, 4'd11, 32'd0, 4'b0101, "sub_eq");

        // Back-to-back with the consumer always ready.
        base = retired;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'($urandom_range(1, 10)), rand_operand(), rand_operand(), 4'(i), 1'b1);
            cycle_step();
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
        cycle_step();
        cycle_step();
        check_eq("b2b_retired", 32'(retired - base), 32'd8);
        drain();

        // Consumer stalls while the producer keeps offering.
        base = accepted;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'($urandom_range(1, 10)), rand_operand(), rand_operand(), 4'(i + 4),
                  1'b0);
            cycle_step();
        end
        check_eq("stall_accepted", 32'(accepted - base), 32'd2);
        drain();

        // Reset with two operations in flight.
        drive(1'b1, 4'd1, 32'd10, 32'd20, 4'd1, 1'b0);
        cycle_step();
        drive(1'b1, 4'd2, 32'd10, 32'd20, 4'd2, 1'b0);
        cycle_step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_result", result, 32'd0);
        check_eq("midrst_out_tag", 32'(out_tag), 32'd0);
        q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_still_empty", 32'(out_valid), 32'd0);
        run_op(4'd8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd12, 32'hFF00_FF00, 4'b0010, "xor_after");

        // Randomized traffic and backpressure.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(9) < 7, 4'($urandom_range(15)), rand_operand(), rand_operand(),
                  4'($urandom_range(15)), $urandom_range(9) < 6);
            cycle_step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
